spi_flash_responder: RTL and testbench

- Synthesizable SPI slave that models a serial NOR flash on the far end of the team's SPI master / XIP bridge.
- Decodes the flash READ command (0x03) and a 24-bit address, fetches 32-bit words from a backing memory port, and shifts them out MSB-first on MISO.
- Used in the SoC sim top in place of the behavioural flash model, and as a device-side block on FPGA.
- All logic runs on the system clock; SCK/SS/MOSI are oversampled.

---
 rtl/spi_flash_pkg.sv | 22 ++
 rtl/spi_flash_responder_sync.sv | 50 +++++
 rtl/spi_flash_responder.sv | 252 +++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash responder.
// Optional fast read is enabled by SPI_FLASH_FAST_READ_EN.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DUMMY_BITS = 8;
  localparam int WORD_BITS  = 32;

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Oversampling synchronizer for SCK/SS/MOSI with edge detection.
// Reset presets the chains to the idle bus (sck low, ss high).
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic sck,
  input  logic ss,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_active,
  output logic ss_start,
  output logic ss_end,
  output logic mosi_s
);

  localparam int M = SYNC_STAGES - 1;

  logic [M:0] sck_q;
  logic [M:0] ss_q;
  logic [M:0] mosi_q;
  logic       sck_d;
  logic       ss_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      sck_q  <= '0;
      ss_q   <= '1;
      mosi_q <= '0;
      sck_d  <= 1'b0;
      ss_d   <= 1'b1;
    end else begin
      sck_q  <= {sck_q[M-1:0], sck};
      ss_q   <= {ss_q[M-1:0], ss};
      mosi_q <= {mosi_q[M-1:0], mosi};
      sck_d  <= sck_q[M];
      ss_d   <= ss_q[M];
    end
  end

  assign sck_rise  = sck_q[M] & ~sck_d;
  assign sck_fall  = ~sck_q[M] & sck_d;
  assign ss_active = ~ss_q[M];
  assign ss_start  = ~ss_q[M] & ss_d;
  assign ss_end    = ss_q[M] & ~ss_d;
  assign mosi_s    = mosi_q[M];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 NOR flash read responder backed by a word memory port.
// Define SPI_FLASH_FAST_READ_EN to also accept 0x0B with 8 dummy bits.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         ADDR_WIDTH  = ADDR_BITS,
  parameter logic [7:0] READ_CMD    = OP_READ
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  spi_sck,
  input  logic                  spi_ss,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_rdata,
  output logic                  busy,
  output logic                  err_late
);

  localparam int SH_W = ADDR_WIDTH - 3;

  state_t state;
  state_t state_n;

  logic sck_rise;
  logic sck_fall;
  logic ss_active;
  logic ss_start;
  logic ss_end;
  logic mosi_s;

  logic [5:0]      bit_cnt;
  logic [SH_W-1:0] sh_in;
  logic [7:0]      opcode;
  logic [4:0]      word_cnt;
  logic [30:0]     sh_out;
  logic [31:0]     hold;
  logic            hold_v;
  logic            pend;
  logic            stale;

  logic                  cnt_clr;
  logic                  cnt_inc;
  logic                  shift_in;
  logic                  data_fall;
  logic                  req_fire;
  logic [ADDR_WIDTH-1:0] req_addr;

`ifdef SPI_FLASH_FAST_READ_EN
  logic fast;
  logic fast_set;
`endif

  spi_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock    (clock),
    .reset    (reset),
    .sck      (spi_sck),
    .ss       (spi_ss),
    .mosi     (spi_mosi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ss_active(ss_active),
    .ss_start (ss_start),
    .ss_end   (ss_end),
    .mosi_s   (mosi_s)
  );

  assign opcode = {sh_in[6:0], mosi_s};
  assign busy   = ss_active & (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    shift_in  = 1'b0;
    data_fall = 1'b0;
    req_fire  = 1'b0;
    req_addr  = mem_addr;
`ifdef SPI_FLASH_FAST_READ_EN
    fast_set  = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (ss_start) begin
          state_n = ST_CMD;
          cnt_clr = 1'b1;
        end
      end
      ST_CMD: begin
        if (sck_rise) begin
          shift_in = 1'b1;
          cnt_inc  = 1'b1;
          if (bit_cnt == 6'(CMD_BITS - 1)) begin
            cnt_clr = 1'b1;
            state_n = ST_IGNORE;
            unique case (1'b1)
              (opcode == READ_CMD): state_n = ST_ADDR;
`ifdef SPI_FLASH_FAST_READ_EN
              (opcode == OP_FAST_READ): begin
                state_n  = ST_ADDR;
                fast_set = 1'b1;
              end
`endif
              default: ;
            endcase
          end
        end
      end
      ST_ADDR: begin
        if (sck_rise) begin
          shift_in = 1'b1;
          cnt_inc  = 1'b1;
          // addr[1:0] still to come; the word address is already known
          if (bit_cnt == 6'(ADDR_WIDTH - 3)) begin
            req_fire = 1'b1;
            req_addr = {sh_in, mosi_s, 2'b00};
          end
          if (bit_cnt == 6'(ADDR_WIDTH - 1)) begin
            cnt_clr = 1'b1;
`ifdef SPI_FLASH_FAST_READ_EN
            state_n = fast ? ST_DUMMY : ST_DATA;
`else
            state_n = ST_DATA;
`endif
          end
        end
      end
`ifdef SPI_FLASH_FAST_READ_EN
      ST_DUMMY: begin
        if (sck_rise) begin
          cnt_inc = 1'b1;
          if (bit_cnt == 6'(DUMMY_BITS - 1)) begin
            cnt_clr = 1'b1;
            state_n = ST_DATA;
          end
        end
      end
`endif
      ST_DATA: begin
        if (sck_fall) begin
          data_fall = 1'b1;
          if (word_cnt == 5'(WORD_BITS - 1)) begin
            req_fire = 1'b1;
            req_addr = mem_addr + ADDR_WIDTH'(4);
          end
        end
      end
      ST_IGNORE: ;
      default: state_n = ST_IDLE;
    endcase
    // SS release beats any same-cycle sck edge
    if (ss_end) begin
      state_n   = ST_IDLE;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      shift_in  = 1'b0;
      data_fall = 1'b0;
      req_fire  = 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
      fast_set  = 1'b0;
`endif
    end
  end

`ifdef SPI_FLASH_FAST_READ_EN
  always_ff @(posedge clock) begin
    if (reset || state == ST_IDLE) fast <= 1'b0;
    else if (fast_set)             fast <= 1'b1;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt  <= '0;
      sh_in    <= '0;
      sh_out   <= '1;
      hold     <= '0;
      hold_v   <= 1'b0;
      pend     <= 1'b0;
      stale    <= 1'b0;
      word_cnt <= '0;
      spi_miso <= 1'b1;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      err_late <= 1'b0;
    end else begin
      mem_req <= 1'b0;
      if (cnt_clr)      bit_cnt <= '0;
      else if (cnt_inc) bit_cnt <= bit_cnt + 6'd1;
      if (shift_in) sh_in <= {sh_in[SH_W-2:0], mosi_s};
      // a stale response belongs to an abandoned fetch
      if (mem_valid) begin
        if (stale) begin
          stale <= 1'b0;
        end else if (pend) begin
          hold   <= mem_rdata;
          hold_v <= 1'b1;
          pend   <= 1'b0;
        end
      end
      if (req_fire) begin
        mem_addr <= req_addr;
        if (!pend && !stale) begin
          mem_req <= 1'b1;
          pend    <= 1'b1;
        end
      end
      if (state != ST_DATA) word_cnt <= '0;
      else if (data_fall)   word_cnt <= word_cnt + 5'd1;
      if (data_fall) begin
        if (word_cnt == 5'd0) begin
          hold_v <= 1'b0;
          if (hold_v) begin
            sh_out   <= hold[30:0];
            spi_miso <= hold[31];
          end else begin
            sh_out   <= '1;
            spi_miso <= 1'b1;
            err_late <= 1'b1;
            if (pend && !mem_valid) begin
              pend  <= 1'b0;
              stale <= 1'b1;
            end
          end
        end else begin
          sh_out   <= {sh_out[29:0], 1'b1};
          spi_miso <= sh_out[30];
        end
      end
      if (ss_end) begin
        hold_v   <= 1'b0;
        spi_miso <= 1'b1;
        if (pend && !mem_valid) begin
          pend  <= 1'b0;
          stale <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI master, memory model,
// immediate-assertion checks.
module tb_spi_flash_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_ss = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;
  logic        err_late;

  int checks = 0;
  int failures = 0;

  logic [127:0] rx;
  logic         busy_at_end;
  logic         busy_after;

  int          mem_delay = 1;
  int          timer = 0;
  logic [23:0] pend_a = '0;
  logic [23:0] addr_log[$];

  spi_flash_responder dut (
    .clock    (clock),
    .reset    (reset),
    .spi_sck  (spi_sck),
    .spi_ss   (spi_ss),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_valid(mem_valid),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .err_late (err_late)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_for(input logic [23:0] a);
    case (a)
      24'h000104: return 32'hDEADBEEF;
      24'hFFFFFC: return 32'h11111111;
      24'h000000: return 32'h22222222;
      24'h000010: return 32'hA5C35A3C;
      24'h000020: return 32'hCAFEF00D;
      default:    return 32'h12345678;
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clock);
      mem_valid = 1'b0;
      if (timer > 0) begin
        timer = timer - 1;
        if (timer == 0) begin
          mem_valid = 1'b1;
          mem_rdata = word_for(pend_a);
        end
      end
      if (mem_req === 1'b1) begin
        addr_log.push_back(mem_addr);
        pend_a = mem_addr;
        timer  = mem_delay;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] hdr, input int nbits);
    rx = '0;
    spi_ss = 1'b0;
    repeat (4) @(negedge clock);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 32) ? hdr[31-i] : 1'b0;
      repeat (4) @(negedge clock);
      rx = {rx[126:0], spi_miso};
      spi_sck = 1'b1;
      repeat (4) @(negedge clock);
      spi_sck = 1'b0;
    end
    repeat (4) @(negedge clock);
    busy_at_end = busy;
    spi_ss = 1'b1;
    spi_mosi = 1'b0;
    repeat (6) @(negedge clock);
    busy_after = busy;
    repeat (14) @(negedge clock);
  endtask

  function automatic int count_addr(input int base, input logic [23:0] a);
    int n = 0;
    for (int k = base; k < addr_log.size(); k++)
      if (addr_log[k] == a) n++;
    return n;
  endfunction

  initial begin
    int base;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_miso", 64'(spi_miso), 64'd1);
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err_late), 64'd0);

    // plain read of one word
    base = addr_log.size();
    xfer(32'h03000104, 64);
    check("rd_data", rx[63:0], {32'hFFFFFFFF, 32'hDEADBEEF});
    check("rd_addr", 64'(addr_log[base]), 64'h000104);
    check("rd_nreq", 64'(count_addr(base, 24'h000104)), 64'd1);
    check("rd_err", 64'(err_late), 64'd0);

    // continuous read across the top of the address space
    base = addr_log.size();
    xfer(32'h03FFFFFC, 96);
    check("wrap_w0", 64'(rx[63:32]), 64'h11111111);
    check("wrap_w1", 64'(rx[31:0]), 64'h22222222);
    check("wrap_a0", 64'(addr_log[base]), 64'hFFFFFC);
    check("wrap_a1", 64'(addr_log[base+1]), 64'h000000);

    // unsupported opcode
    base = addr_log.size();
    xfer(32'h9F000000, 64);
    check("ign_miso", rx[63:0], 64'hFFFFFFFF_FFFFFFFF);
    check("ign_nreq", 64'(addr_log.size() - base), 64'd0);
    check("ign_busy", 64'(busy_at_end), 64'd1);
    check("ign_idle", 64'(busy_after), 64'd0);

    // response arrives after the data phase started
    mem_delay = 100;
    xfer(32'h03000040, 64);
    check("late_data", 64'(rx[31:0]), 64'hFFFFFFFF);
    check("late_err", 64'(err_late), 64'd1);
    mem_delay = 1;
    repeat (120) @(negedge clock);
    xfer(32'h03000104, 64);
    check("post_data", 64'(rx[31:0]), 64'hDEADBEEF);
    check("post_err", 64'(err_late), 64'd1);

    // abort during the address, then a fresh read
    base = addr_log.size();
    xfer(32'h03ABCD00, 28);
    check("abort_nreq", 64'(addr_log.size() - base), 64'd0);
    xfer(32'h03000010, 64);
    check("abort_data", 64'(rx[31:0]), 64'hA5C35A3C);
    check("abort_addr", 64'(addr_log[base]), 64'h000010);

    // fast read opcode
    base = addr_log.size();
    xfer(32'h0B000020, 72);
`ifdef SPI_FLASH_FAST_READ_EN
    check("fast_data", 64'(rx[31:0]), 64'hCAFEF00D);
    check("fast_addr", 64'(addr_log[base]), 64'h000020);
`else
    check("fast_ign", rx[63:0], 64'hFFFFFFFF_FFFFFFFF);
    check("fast_nreq", 64'(addr_log.size() - base), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
